// File: rtl/load_group_pkg.sv
// Controller load-code bus shared with the datapath.
// Codes 12..15 are unassigned and decode as NO_OP.
package loadGroup;

  typedef enum logic [3:0] {
    NO_OP         = 4'd0,
    NEXTPC_IMM24  = 4'd1,
    RFA_IMM19     = 4'd2,
    NEXTPC_IMM21B = 4'd3,
    NEXTPC_IMM21C = 4'd4,
    NULL_COMBO    = 4'd5,
    NULL_RFB      = 4'd6,
    RFA_IMM16A    = 4'd7,
    RFA_IMM16B    = 4'd8,
    RFA_IMM21A    = 4'd9,
    RFA_IMM5      = 4'd10,
    RFA_RFB       = 4'd11
  } controlBus;

endpackage

// File: rtl/operand_load_unit_pkg.sv
// Shared types and immediate field positions for operand_load_unit.
// Field positions assume a 32-bit instruction word.
package operandLoadPkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ZERO,
    RFA,
    NEXTPC
  } srcA_e;

  typedef enum logic [3:0] {
    RFB,
    IMM24,
    IMM19,
    IMM21B,
    IMM21C,
    IMM16A,
    IMM16B,
    IMM21A,
    IMM5,
    UPPER16
  } srcB_e;

  localparam int IMM24_HI   = 23;
  localparam int IMM19_HI   = 18;
  localparam int IMM21_HI   = 20;
  localparam int IMM16_HI   = 15;
  localparam int IMM16B_LHI = 10;
  localparam int IMM5_HI    = 4;
  localparam int IMMX_UHI   = 25;
  localparam int IMMX_ULO   = 21;
  localparam int BR_SHIFT   = 2;

endpackage

// File: rtl/operand_load_unit_immediate_extractor.sv
// Combinational immediate extraction and extension
// from the latched instruction word.
module immediate_extractor
  import operandLoadPkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic [DATA_WIDTH-1:0]  o_imm24,
  output logic [DATA_WIDTH-1:0]  o_imm19,
  output logic [DATA_WIDTH-1:0]  o_imm21b,
  output logic [DATA_WIDTH-1:0]  o_imm21c,
  output logic [DATA_WIDTH-1:0]  o_imm16a,
  output logic [DATA_WIDTH-1:0]  o_imm16b,
  output logic [DATA_WIDTH-1:0]  o_imm21a,
  output logic [DATA_WIDTH-1:0]  o_imm5,
  output logic [DATA_WIDTH-1:0]  o_upper16
);

  logic [20:0] w_c21;
  logic [15:0] w_c16;
  logic        w_unused_hi;

  assign w_c21 = {i_instr[IMMX_UHI:IMMX_ULO],
                  i_instr[IMM16_HI:0]};
  assign w_c16 = {i_instr[IMMX_UHI:IMMX_ULO],
                  i_instr[IMM16B_LHI:0]};

  assign o_imm24 =
    DATA_WIDTH'($signed(i_instr[IMM24_HI:0]))
    << BR_SHIFT;
  assign o_imm19 =
    DATA_WIDTH'($signed(i_instr[IMM19_HI:0]))
    << BR_SHIFT;
  assign o_imm21b =
    DATA_WIDTH'($signed(i_instr[IMM21_HI:0]));
  assign o_imm21c = DATA_WIDTH'($signed(w_c21));
  assign o_imm16a =
    DATA_WIDTH'($signed(i_instr[IMM16_HI:0]));
  assign o_imm16b = DATA_WIDTH'($signed(w_c16));
  assign o_imm21a =
    DATA_WIDTH'($signed(i_instr[IMM21_HI:0]));
  assign o_imm5 = DATA_WIDTH'(i_instr[IMM5_HI:0]);
  assign o_upper16 =
    DATA_WIDTH'({i_instr[IMM16_HI:0], 16'h0});

  // Opcode bits are decoded upstream, not here.
  assign w_unused_hi =
    ^i_instr[INSTR_WIDTH-1:IMMX_UHI+1];

endmodule

// File: rtl/operand_load_unit.sv
// Operand load unit: decodes load codes, registers operands A/B.
// Optional write-back forwarding: define OPERAND_LOAD_FORWARD_EN.
module operand_load_unit
  import loadGroup::*;
  import operandLoadPkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  controlBus              loadControl,
  input  logic [INSTR_WIDTH-1:0] instructionWord,
  input  logic [DATA_WIDTH-1:0]  nextPc,
  input  logic [DATA_WIDTH-1:0]  rfA,
  input  logic [DATA_WIDTH-1:0]  rfB,
`ifdef OPERAND_LOAD_FORWARD_EN
  input  logic                   wbEnable,
  input  logic [4:0]             wbAddr,
  input  logic [DATA_WIDTH-1:0]  wbData,
  input  logic [4:0]             rfAAddr,
  input  logic [4:0]             rfBAddr,
`endif
  output logic [DATA_WIDTH-1:0]  operandA,
  output logic [DATA_WIDTH-1:0]  operandB,
  output logic                   operandValid,
  input  logic                   operandReady,
  output logic                   loadStall
);

  state_e                r_state;
  state_e                w_state_nx;
  logic [DATA_WIDTH-1:0] r_opA;
  logic [DATA_WIDTH-1:0] r_opB;
  logic [DATA_WIDTH-1:0] w_rfA;
  logic [DATA_WIDTH-1:0] w_rfB;
  logic [DATA_WIDTH-1:0] w_muxA;
  logic [DATA_WIDTH-1:0] w_muxB;
  srcA_e                 w_srcA;
  srcB_e                 w_srcB;
  logic                  w_load;
  logic                  w_capture;

  logic [DATA_WIDTH-1:0] w_imm24;
  logic [DATA_WIDTH-1:0] w_imm19;
  logic [DATA_WIDTH-1:0] w_imm21b;
  logic [DATA_WIDTH-1:0] w_imm21c;
  logic [DATA_WIDTH-1:0] w_imm16a;
  logic [DATA_WIDTH-1:0] w_imm16b;
  logic [DATA_WIDTH-1:0] w_imm21a;
  logic [DATA_WIDTH-1:0] w_imm5;
  logic [DATA_WIDTH-1:0] w_upper16;

  immediate_extractor #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_imm (
    .i_instr   (instructionWord),
    .o_imm24   (w_imm24),
    .o_imm19   (w_imm19),
    .o_imm21b  (w_imm21b),
    .o_imm21c  (w_imm21c),
    .o_imm16a  (w_imm16a),
    .o_imm16b  (w_imm16b),
    .o_imm21a  (w_imm21a),
    .o_imm5    (w_imm5),
    .o_upper16 (w_upper16)
  );

`ifdef OPERAND_LOAD_FORWARD_EN
  // r0 is hardwired zero, so a write to it is never forwarded.
  assign w_rfA = (wbEnable && wbAddr != 5'd0 &&
                  wbAddr == rfAAddr) ? wbData : rfA;
  assign w_rfB = (wbEnable && wbAddr != 5'd0 &&
                  wbAddr == rfBAddr) ? wbData : rfB;
`else
  assign w_rfA = rfA;
  assign w_rfB = rfB;
`endif

  always_comb begin
    w_load = 1'b1;
    w_srcA = ZERO;
    w_srcB = RFB;
    case (loadControl)
      NEXTPC_IMM24:  begin w_srcA = NEXTPC; w_srcB = IMM24;   end
      RFA_IMM19:     begin w_srcA = RFA;    w_srcB = IMM19;   end
      NEXTPC_IMM21B: begin w_srcA = NEXTPC; w_srcB = IMM21B;  end
      NEXTPC_IMM21C: begin w_srcA = NEXTPC; w_srcB = IMM21C;  end
      NULL_COMBO:    begin w_srcA = ZERO;   w_srcB = UPPER16; end
      NULL_RFB:      begin w_srcA = ZERO;   w_srcB = RFB;     end
      RFA_IMM16A:    begin w_srcA = RFA;    w_srcB = IMM16A;  end
      RFA_IMM16B:    begin w_srcA = RFA;    w_srcB = IMM16B;  end
      RFA_IMM21A:    begin w_srcA = RFA;    w_srcB = IMM21A;  end
      RFA_IMM5:      begin w_srcA = RFA;    w_srcB = IMM5;    end
      RFA_RFB:       begin w_srcA = RFA;    w_srcB = RFB;     end
      default:       w_load = 1'b0;
    endcase
  end

  always_comb begin
    w_muxA = '0;
    case (w_srcA)
      RFA:     w_muxA = w_rfA;
      NEXTPC:  w_muxA = nextPc;
      default: w_muxA = '0;
    endcase
  end

  always_comb begin
    w_muxB = w_rfB;
    case (w_srcB)
      IMM24:   w_muxB = w_imm24;
      IMM19:   w_muxB = w_imm19;
      IMM21B:  w_muxB = w_imm21b;
      IMM21C:  w_muxB = w_imm21c;
      IMM16A:  w_muxB = w_imm16a;
      IMM16B:  w_muxB = w_imm16b;
      IMM21A:  w_muxB = w_imm21a;
      IMM5:    w_muxB = w_imm5;
      UPPER16: w_muxB = w_upper16;
      default: w_muxB = w_rfB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= EMPTY;
    else if (enable) r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      EMPTY: if (w_load) w_state_nx = FULL;
      FULL: begin
        if (operandReady)
          w_state_nx = w_load ? FULL : EMPTY;
      end
      default: w_state_nx = EMPTY;
    endcase
  end

  always_comb begin
    operandValid = (r_state == FULL);
    loadStall    = operandValid & ~operandReady;
  end

  // A held pair blocks capture until the consumer takes it.
  assign w_capture = enable & w_load &
                     ((r_state == EMPTY) | operandReady);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opA <= '0;
      r_opB <= '0;
    end else if (w_capture) begin
      r_opA <= w_muxA;
      r_opB <= w_muxB;
    end
  end

  assign operandA = r_opA;
  assign operandB = r_opB;

endmodule

// File: tb/tb_operand_load_unit.sv
// Bench for operand_load_unit: directed table, corner sequences,
// randomized run against an arithmetic reference model.
module tb_operand_load_unit;
  import loadGroup::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  controlBus   loadControl;
  logic [31:0] instructionWord;
  logic [31:0] nextPc;
  logic [31:0] rfA;
  logic [31:0] rfB;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        operandValid;
  logic        operandReady;
  logic        loadStall;
  logic        wbEnable;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic [4:0]  rfAAddr;
  logic [4:0]  rfBAddr;

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] instr;
    logic [31:0] npc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rdy;
    logic        ev;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t tv[16];

  always #5 clk = ~clk;

  operand_load_unit dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .loadControl     (loadControl),
    .instructionWord (instructionWord),
    .nextPc          (nextPc),
    .rfA             (rfA),
    .rfB             (rfB),
`ifdef OPERAND_LOAD_FORWARD_EN
    .wbEnable        (wbEnable),
    .wbAddr          (wbAddr),
    .wbData          (wbData),
    .rfAAddr         (rfAAddr),
    .rfBAddr         (rfBAddr),
`endif
    .operandA        (operandA),
    .operandB        (operandB),
    .operandValid    (operandValid),
    .operandReady    (operandReady),
    .loadStall       (loadStall)
  );

  function automatic vec_t mk(
    logic [3:0] code, logic [31:0] instr, logic [31:0] npc,
    logic [31:0] ra, logic [31:0] rb, logic rdy,
    logic ev, logic [31:0] ea, logic [31:0] eb);
    vec_t v;
    v.code = code; v.instr = instr; v.npc = npc;
    v.ra = ra; v.rb = rb; v.rdy = rdy;
    v.ev = ev; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic longint fld(longint w, int lo, int n);
    longint sh = w / (longint'(1) << lo);
    return sh % (longint'(1) << n);
  endfunction

  function automatic longint sx(longint v, int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) ? v - 2 * half : v;
  endfunction

  function automatic logic [31:0] tr(longint v);
    logic [63:0] x = v;
    return x[31:0];
  endfunction

  function automatic logic [31:0] effA();
`ifdef OPERAND_LOAD_FORWARD_EN
    if (wbEnable && wbAddr != 0 && wbAddr == rfAAddr)
      return wbData;
`endif
    return rfA;
  endfunction

  function automatic logic [31:0] effB();
`ifdef OPERAND_LOAD_FORWARD_EN
    if (wbEnable && wbAddr != 0 && wbAddr == rfBAddr)
      return wbData;
`endif
    return rfB;
  endfunction

  task automatic ref_pair(output bit ld,
                          output logic [31:0] a,
                          output logic [31:0] b);
    longint w = longint'(instructionWord);
    int c = int'(loadControl);
    ld = 1; a = 0; b = 0;
    case (c)
      1:  begin a = nextPc; b = tr(sx(fld(w,0,24),24) * 4); end
      2:  begin a = effA(); b = tr(sx(fld(w,0,19),19) * 4); end
      3:  begin a = nextPc; b = tr(sx(fld(w,0,21),21)); end
      4:  begin a = nextPc;
            b = tr(sx(fld(w,21,5) * 65536 + fld(w,0,16), 21));
          end
      5:  begin a = 0; b = tr(fld(w,0,16) * 65536); end
      6:  begin a = 0; b = effB(); end
      7:  begin a = effA(); b = tr(sx(fld(w,0,16),16)); end
      8:  begin a = effA();
            b = tr(sx(fld(w,21,5) * 2048 + fld(w,0,11), 16));
          end
      9:  begin a = effA(); b = tr(sx(fld(w,0,21),21)); end
      10: begin a = effA(); b = tr(fld(w,0,5)); end
      11: begin a = effA(); b = effB(); end
      default: ld = 0;
    endcase
  endtask

  task automatic model_edge();
    bit ld;
    logic [31:0] a, b;
    if (reset) begin
      m_valid = 0; m_a = 0; m_b = 0;
    end else if (enable && (!m_valid || operandReady)) begin
      ref_pair(ld, a, b);
      if (ld) begin
        m_valid = 1; m_a = a; m_b = b;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, " valid"}, 32'(operandValid), 32'(m_valid));
    check({tag, " opA"}, operandA, m_a);
    check({tag, " opB"}, operandB, m_b);
    check({tag, " stall"}, 32'(loadStall),
          32'(m_valid & ~operandReady));
  endtask

  initial begin
    tv[0]  = mk(4'd7,  32'h0000_FFFE, 0, 32'h10, 0, 0,
                1, 32'h10, 32'hFFFF_FFFE);
    tv[1]  = mk(4'd0,  0, 0, 0, 0, 1,
                0, 32'h10, 32'hFFFF_FFFE);
    tv[2]  = mk(4'd1,  32'h00FF_FFFF, 32'h1000, 0, 0, 0,
                1, 32'h1000, 32'hFFFF_FFFC);
    tv[3]  = mk(4'd11, 0, 0, 1, 2, 0,
                1, 32'h1000, 32'hFFFF_FFFC);
    tv[4]  = mk(4'd11, 0, 0, 1, 2, 0,
                1, 32'h1000, 32'hFFFF_FFFC);
    tv[5]  = mk(4'd11, 0, 0, 1, 2, 0,
                1, 32'h1000, 32'hFFFF_FFFC);
    tv[6]  = mk(4'd11, 0, 0, 1, 2, 1, 1, 1, 2);
    tv[7]  = mk(4'd5,  32'h1234_ABCD, 0, 3, 4, 1,
                1, 0, 32'hABCD_0000);
    tv[8]  = mk(4'd6,  0, 0, 5, 32'hDEAD_BEEF, 1,
                1, 0, 32'hDEAD_BEEF);
    tv[9]  = mk(4'd15, 0, 0, 6, 7, 1,
                0, 0, 32'hDEAD_BEEF);
    tv[10] = mk(4'd10, 32'hFFFF_FFF3, 0, 5, 0, 1,
                1, 5, 32'h13);
    tv[11] = mk(4'd2,  32'h0004_0000, 0, 7, 0, 1,
                1, 7, 32'hFFF0_0000);
    tv[12] = mk(4'd3,  32'h0010_0000, 32'h2000, 0, 0, 1,
                1, 32'h2000, 32'hFFF0_0000);
    tv[13] = mk(4'd4,  32'h0200_0001, 32'h3000, 0, 0, 1,
                1, 32'h3000, 32'hFFF0_0001);
    tv[14] = mk(4'd8,  32'h0020_0005, 0, 9, 0, 1,
                1, 9, 32'h805);
    tv[15] = mk(4'd9,  32'h000F_FFFF, 0, 32'hA, 0, 1,
                1, 32'hA, 32'h000F_FFFF);

    reset = 1; enable = 1; loadControl = NO_OP;
    instructionWord = 0; nextPc = 0; rfA = 0; rfB = 0;
    operandReady = 0;
    wbEnable = 0; wbAddr = 0; wbData = 0;
    rfAAddr = 0; rfBAddr = 0;
    m_valid = 0; m_a = 0; m_b = 0;
    #1;
    tick();
    check("reset valid", 32'(operandValid), 0);
    check("reset opA", operandA, 0);
    check("reset opB", operandB, 0);
    reset = 0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle valid", 32'(operandValid), 0);
    end

    for (int i = 0; i < 16; i++) begin
      loadControl     = controlBus'(tv[i].code);
      instructionWord = tv[i].instr;
      nextPc          = tv[i].npc;
      rfA             = tv[i].ra;
      rfB             = tv[i].rb;
      operandReady    = tv[i].rdy;
      tick();
      check($sformatf("vec%0d valid", i),
            32'(operandValid), 32'(tv[i].ev));
      check($sformatf("vec%0d opA", i), operandA, tv[i].ea);
      check($sformatf("vec%0d opB", i), operandB, tv[i].eb);
      check($sformatf("vec%0d stall", i), 32'(loadStall),
            32'(tv[i].ev & ~tv[i].rdy));
    end

    enable = 0; operandReady = 1; loadControl = RFA_RFB;
    rfA = 32'h77; rfB = 32'h88;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frozen valid", 32'(operandValid), 1);
      check("frozen opA", operandA, 32'hA);
      check("frozen stall", 32'(loadStall), 0);
    end
    operandReady = 0;
    #1;
    check("frozen comb stall", 32'(loadStall), 1);
    reset = 1;
    tick();
    check("midreset valid", 32'(operandValid), 0);
    check("midreset opA", operandA, 0);
    check("midreset opB", operandB, 0);
    reset = 0; enable = 1;

`ifdef OPERAND_LOAD_FORWARD_EN
    loadControl = RFA_RFB; operandReady = 1;
    wbEnable = 1; wbAddr = 7; rfAAddr = 7; rfBAddr = 3;
    wbData = 32'hABCD; rfA = 0; rfB = 32'h22;
    tick();
    check("fwd opA", operandA, 32'hABCD);
    check("fwd opB", operandB, 32'h22);
    wbAddr = 0; rfAAddr = 0; rfA = 32'h55;
    tick();
    check("fwd r0 opA", operandA, 32'h55);
    wbEnable = 0;
`endif

    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 63) == 0);
      enable          = ($urandom_range(0, 3) != 0);
      operandReady    = $urandom_range(0, 1) == 1;
      loadControl     = controlBus'($urandom_range(0, 15));
      instructionWord = $urandom;
      nextPc          = $urandom;
      rfA             = $urandom;
      rfB             = $urandom;
      wbEnable        = $urandom_range(0, 1) == 1;
      wbAddr          = 5'($urandom_range(0, 3));
      rfAAddr         = 5'($urandom_range(0, 3));
      rfBAddr         = 5'($urandom_range(0, 3));
      wbData          = $urandom;
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
